// File: rtl/exec_wb_pipe_pkg.sv
// Shared defaults and the per-stage record carried from execute to writeback.
package exec_wb_pipe_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int AW_DEF    = 5;
  localparam int DEPTH_DEF = 2;

  // Field order {valid, we, rd, data}; the top rebuilds this shape at its own widths.
  typedef struct packed {
    logic                valid;
    logic                we;
    logic [AW_DEF-1:0]   rd;
    logic [XLEN_DEF-1:0] data;
  } stage_t;

endpackage

// File: rtl/exec_wb_stage.sv
// One execute-to-writeback register stage: clear beats hold, hold beats load.
module exec_wb_stage
  import exec_wb_pipe_pkg::*;
#(
  parameter type rec_t = stage_t
) (
  input  logic clk,
  input  logic reset,
  input  logic hold_i,
  input  logic clear_i,
  input  rec_t d_i,
  output rec_t q_o
);

  rec_t rec_q, rec_d;

  always_comb begin
    rec_d = rec_q;
    if (clear_i) begin
      rec_d = '0;
    end else if (!hold_i) begin
      rec_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rec_q <= '0;
    end else begin
      rec_q <= rec_d;
    end
  end

  assign q_o = rec_q;

endmodule

// File: rtl/exec_wb_pipe.sv
// Execute-to-writeback pipe with stall/flush, operand forwarding and a retire counter.
module exec_wb_pipe
  import exec_wb_pipe_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_we,
  input  logic            in_is_load,
  input  logic [AW-1:0]   in_rd,
  input  logic [XLEN-1:0] in_alu,
  input  logic [XLEN-1:0] in_imm,
  input  logic            stall,
  input  logic            flush,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [XLEN-1:0] rf_rdata1,
  input  logic [XLEN-1:0] rf_rdata2,
  output logic [XLEN-1:0] fwd_data1,
  output logic [XLEN-1:0] fwd_data2,
  output logic            rf_we,
  output logic [AW-1:0]   rf_waddr,
  output logic [XLEN-1:0] rf_wdata,
  output logic            busy,
  output logic [31:0]     retire_cnt
);

  typedef struct packed {
    logic            valid;
    logic            we;
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } rec_t;

  rec_t        in_rec;
  rec_t        stg_q [DEPTH];
  rec_t        fin;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  // Handshake: a result transfers on in_valid && in_ready at the rising edge.
  assign in_ready = !stall && !flush;

  always_comb begin
    in_rec       = '0;
    in_rec.valid = 1'b1;
    in_rec.we    = in_we;
    in_rec.rd    = in_rd;
    in_rec.data  = in_is_load ? in_imm : in_alu;
  end

  // Flush empties every stage; the final stage's contents retire during that same cycle.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    rec_t d;
    logic clr;
    if (i == 0) begin : g_first
      assign d   = in_rec;
      assign clr = flush || (!stall && !in_valid);
    end else begin : g_next
      assign d   = stg_q[i-1];
      assign clr = flush;
    end
    exec_wb_stage #(.rec_t(rec_t)) u_stage (
      .clk     (clk),
      .reset   (reset),
      .hold_i  (stall),
      .clear_i (clr),
      .d_i     (d),
      .q_o     (stg_q[i])
    );
  end

  assign fin      = stg_q[DEPTH-1];
  assign rf_we    = fin.valid && fin.we && (fin.rd != '0) && (!stall || flush);
  assign rf_waddr = fin.rd;
  assign rf_wdata = fin.data;

  // Scan oldest to youngest so the youngest matching stage wins.
  always_comb begin
    fwd_data1 = rf_rdata1;
    fwd_data2 = rf_rdata2;
    busy      = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      busy = busy | stg_q[i].valid;
      if (stg_q[i].valid && stg_q[i].we && (stg_q[i].rd != '0) && (stg_q[i].rd == rs1)) begin
        fwd_data1 = stg_q[i].data;
      end
      if (stg_q[i].valid && stg_q[i].we && (stg_q[i].rd != '0) && (stg_q[i].rd == rs2)) begin
        fwd_data2 = stg_q[i].data;
      end
    end
  end

  assign retire_cnt_d = rf_we ? retire_cnt_q + 32'd1 : retire_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;

endmodule
